// File: rtl/mixed_int_accum_ctrl.sv
// mixed_int_accum_ctrl
// Sequencing controller that sums a programmable number of signed short
// terms into one signed long accumulator. The accumulator wraps modulo
// 2^OUT_WIDTH, and a sticky flag records whether any add overflowed.
// Terms arrive on a valid/ready input and the finished result leaves on a
// valid/ready output. The result is the accumulator register itself, so
// there is no combinational path from in_data_i to out_data_o.
module mixed_int_accum_ctrl #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int MAX_TERMS = 32,
  parameter int CNT_WIDTH = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_terms_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_ovf_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TERMS);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  state_t                 state;
  state_t                 state_next;
  logic [OUT_WIDTH-1:0]   acc;
  logic                   ovf;
  logic [CNT_WIDTH-1:0]   count;
  logic [CNT_WIDTH-1:0]   target;

  logic                   start_ok;
  logic [CNT_WIDTH-1:0]   start_target;
  logic                   accept;
  logic                   last_term;
  logic [OUT_WIDTH-1:0]   ext;
  logic [OUT_WIDTH-1:0]   sum;
  logic                   add_ovf;

  // Decode the start request, saturate the term count and form the
  // sign-extended add together with its signed-overflow flag.
  always_comb begin
    start_ok     = (state == ST_IDLE) && start_i;
    start_target = (num_terms_i > MAX_CNT) ? MAX_CNT : num_terms_i;
    accept       = (state == ST_ACCUM) && in_valid_i;
    last_term    = ((count + ONE_CNT) == target);
    ext          = {{(OUT_WIDTH - IN_WIDTH){in_data_i[IN_WIDTH-1]}}, in_data_i};
    sum          = acc + ext;
    add_ovf      = (acc[OUT_WIDTH-1] == ext[OUT_WIDTH-1]) &&
                   (sum[OUT_WIDTH-1] != acc[OUT_WIDTH-1]);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero-term request skips straight to presenting 0.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_next = (start_target == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept && last_term) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Accumulator, term counter, target and sticky overflow. Once the result
  // has been handed off, acc keeps its value until the next start clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc    <= '0;
      ovf    <= 1'b0;
      count  <= '0;
      target <= '0;
    end else if (start_ok) begin
      acc    <= '0;
      ovf    <= 1'b0;
      count  <= '0;
      target <= start_target;
    end else if (accept) begin
      acc    <= sum;
      ovf    <= ovf | add_ovf;
      count  <= count + ONE_CNT;
    end
  end

  // Handshake and status outputs depend on the state alone.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state)
      ST_ACCUM: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
      end
    endcase
  end

  assign out_data_o = acc;
  assign out_ovf_o  = ovf;

endmodule
